fib_seq_engine: RTL and testbench

FIB_SEQ_ENGINE -- requirements
Module: fib_seq_engine

---
 rtl/fib_seq_engine.sv | 162 ++++++++++++++++
 tb/tb_fib_seq_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_engine.sv
// ---------------------------------------------------------------------------
// fib_seq_engine
//
// Iterative Fibonacci-style sequence engine. A start request in IDLE latches
// an iteration count n and a seed pair (a, b). Each RUN cycle then performs
// (n, a, b) <= (n-1, b, f(a+b)). When n reaches zero, the final a is published
// on result with a one-cycle w_enable pulse. The addition either wraps modulo
// 2^DATA_W or saturates to all-ones. A sticky overflow flag records any carry
// out of any addition made during the job.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   r_enable  : start request, sampled only in IDLE
//   init_n    : iteration count (unsigned), latched on start
//   init_a    : seed a, latched on start
//   init_b    : seed b, latched on start
//   sat_en    : 0 = wrap arithmetic, 1 = saturating arithmetic, latched on start
//   busy      : high whenever the engine is not IDLE
//   w_enable  : one-cycle result-valid pulse
//   result    : final a, held until the next w_enable pulse
//   overflow  : sticky carry flag of the job, valid with w_enable, held
// ---------------------------------------------------------------------------
module fib_seq_engine #(
    parameter int DATA_W = 32,
    parameter int N_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_enable,
    input  logic [N_W-1:0]    init_n,
    input  logic [DATA_W-1:0] init_a,
    input  logic [DATA_W-1:0] init_b,
    input  logic              sat_en,
    output logic              busy,
    output logic              w_enable,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One sequence step: returns {carry, f(a+b)}. The sum is formed one bit
    // wider than the operands so the carry is never lost.
    function automatic logic [DATA_W:0] fib_step(
        input logic [DATA_W-1:0] a_v,
        input logic [DATA_W-1:0] b_v,
        input logic              sat_v
    );
        logic [DATA_W:0]   sum_v;
        logic [DATA_W-1:0] f_v;
        sum_v = {1'b0, a_v} + {1'b0, b_v};
        if (sat_v && sum_v[DATA_W]) begin
            f_v = {DATA_W{1'b1}};
        end else begin
            f_v = sum_v[DATA_W-1:0];
        end
        return {sum_v[DATA_W], f_v};
    endfunction

    state_t            state_r,    state_next_s;
    logic [N_W-1:0]    n_r,        n_next_s;
    logic [DATA_W-1:0] a_r,        a_next_s;
    logic [DATA_W-1:0] b_r,        b_next_s;
    logic              sat_r,      sat_next_s;
    logic              flag_r,     flag_next_s;
    logic [DATA_W-1:0] result_r,   result_next_s;
    logic              overflow_r, overflow_next_s;
    logic              wen_r,      wen_next_s;
    logic              busy_r,     busy_next_s;
    logic [DATA_W:0]   step_s;

    // Next-state and datapath update for IDLE/RUN/DONE sequencing.
    always_comb begin
        state_next_s    = state_r;
        n_next_s        = n_r;
        a_next_s        = a_r;
        b_next_s        = b_r;
        sat_next_s      = sat_r;
        flag_next_s     = flag_r;
        result_next_s   = result_r;
        overflow_next_s = overflow_r;
        wen_next_s      = 1'b0;
        step_s          = fib_step(a_r, b_r, sat_r);

        case (state_r)
            ST_IDLE: begin
                if (r_enable) begin
                    n_next_s     = init_n;
                    a_next_s     = init_a;
                    b_next_s     = init_b;
                    sat_next_s   = sat_en;
                    flag_next_s  = 1'b0;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (n_r != {N_W{1'b0}}) begin
                    // Counter only decrements while non-zero, so the maximum
                    // count cannot wrap.
                    n_next_s    = n_r - N_W'(1);
                    a_next_s    = b_r;
                    b_next_s    = step_s[DATA_W-1:0];
                    flag_next_s = flag_r | step_s[DATA_W];
                end else begin
                    result_next_s   = a_r;
                    overflow_next_s = flag_r;
                    wen_next_s      = 1'b1;
                    state_next_s    = ST_DONE;
                end
            end
            ST_DONE: begin
                // No start is taken here; the next IDLE edge may accept one.
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State, datapath and registered output update with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            n_r        <= {N_W{1'b0}};
            a_r        <= {DATA_W{1'b0}};
            b_r        <= {DATA_W{1'b0}};
            sat_r      <= 1'b0;
            flag_r     <= 1'b0;
            result_r   <= {DATA_W{1'b0}};
            overflow_r <= 1'b0;
            wen_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            n_r        <= n_next_s;
            a_r        <= a_next_s;
            b_r        <= b_next_s;
            sat_r      <= sat_next_s;
            flag_r     <= flag_next_s;
            result_r   <= result_next_s;
            overflow_r <= overflow_next_s;
            wen_r      <= wen_next_s;
            busy_r     <= busy_next_s;
        end
    end

    assign busy     = busy_r;
    assign w_enable = wen_r;
    assign result   = result_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_fib_seq_engine.sv
// ---------------------------------------------------------------------------
// tb_fib_seq_engine
//
// Directed self-checking bench for fib_seq_engine (default DATA_W=32, N_W=6).
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same offset. Latency is counted in rising edges after the edge that
// accepted the start.
// ---------------------------------------------------------------------------
module tb_fib_seq_engine;

    logic        clk;
    logic        rst_n;
    logic        r_enable;
    logic [5:0]  init_n;
    logic [31:0] init_a;
    logic [31:0] init_b;
    logic        sat_en;
    logic        busy;
    logic        w_enable;
    logic [31:0] result;
    logic        overflow;

    int total;
    int bad;

    // Values captured by wait_job
    int          lat;
    int          busy_cnt;
    int          pulse_cnt;
    logic [31:0] res_cap;
    logic        ovf_cap;
    bit          timed_out;

    fib_seq_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r_enable (r_enable),
        .init_n   (init_n),
        .init_a   (init_a),
        .init_b   (init_b),
        .sat_en   (sat_en),
        .busy     (busy),
        .w_enable (w_enable),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a start request; returns 1 unit after the accepting edge.
    task automatic start_job(input logic [5:0] n, input logic [31:0] a,
                             input logic [31:0] b, input logic s, input bit hold);
        init_n   = n;
        init_a   = a;
        init_b   = b;
        sat_en   = s;
        r_enable = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) r_enable = 1'b0;
    endtask

    // Follow a running job until busy drops (bounded), recording the latency
    // of the first w_enable pulse and the outputs seen with it.
    task automatic wait_job();
        lat       = -1;
        busy_cnt  = busy ? 1 : 0;
        pulse_cnt = 0;
        res_cap   = 32'd0;
        ovf_cap   = 1'b0;
        timed_out = 1'b1;
        for (int j = 1; j <= 200; j++) begin
            @(posedge clk);
            #1;
            if (w_enable) begin
                if (pulse_cnt == 0) begin
                    lat     = j;
                    res_cap = result;
                    ovf_cap = overflow;
                end
                pulse_cnt++;
            end
            if (busy) begin
                busy_cnt++;
            end else begin
                timed_out = 1'b0;
                break;
            end
        end
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL job_timeout: busy still high after 200 edges, want low");
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        r_enable = 1'b0;
        init_n   = 6'd0;
        init_a   = 32'd0;
        init_b   = 32'd0;
        sat_en   = 1'b0;
        #2;
        total++;
        if ({busy, w_enable, overflow} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000", {busy, w_enable, overflow});
        end
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL reset_result: got %0d want 0", result);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // n=10 from (0,1) gives 55; started at the first edge after reset release.
    task automatic test_basic();
        start_job(6'd10, 32'd0, 32'd1, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_accept: busy got %b want 1", busy);
        end
        wait_job();
        total++;
        if (lat !== 11) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 11", lat);
        end
        total++;
        if (res_cap !== 32'd55 || ovf_cap !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got %0d/%b want 55/0", res_cap, ovf_cap);
        end
        total++;
        if (busy_cnt !== 12 || pulse_cnt !== 1) begin
            bad++;
            $display("FAIL basic_busy: busy=%0d pulses=%0d want 12/1", busy_cnt, pulse_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (result !== 32'd55 || w_enable !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold: got %0d/%b want 55/0", result, w_enable);
        end
    endtask

    task automatic test_zero_n();
        start_job(6'd0, 32'd7, 32'd9, 1'b0, 1'b0);
        wait_job();
        total++;
        if (lat !== 1 || res_cap !== 32'd7 || ovf_cap !== 1'b0) begin
            bad++;
            $display("FAIL zero_n: lat=%0d res=%0d ovf=%b want 1/7/0", lat, res_cap, ovf_cap);
        end
    endtask

    // F(48)=4807526976, modulo 2^32 = 512559680.
    task automatic test_wrap();
        start_job(6'd48, 32'd0, 32'd1, 1'b0, 1'b0);
        wait_job();
        total++;
        if (lat !== 49 || res_cap !== 32'd512559680 || ovf_cap !== 1'b1) begin
            bad++;
            $display("FAIL wrap: lat=%0d res=%0d ovf=%b want 49/512559680/1", lat, res_cap, ovf_cap);
        end
    endtask

    task automatic test_saturate();
        start_job(6'd48, 32'd0, 32'd1, 1'b1, 1'b0);
        wait_job();
        total++;
        if (res_cap !== 32'hFFFF_FFFF || ovf_cap !== 1'b1) begin
            bad++;
            $display("FAIL saturate: res=%h ovf=%b want ffffffff/1", res_cap, ovf_cap);
        end
        // Overflow of a job whose final a stays small: (0xFFFFFFFF,1) wraps
        // in b only; n=1 leaves a=1 but the carry still counts.
        start_job(6'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_job();
        total++;
        if (res_cap !== 32'd1 || ovf_cap !== 1'b1) begin
            bad++;
            $display("FAIL hidden_carry: res=%0d ovf=%b want 1/1", res_cap, ovf_cap);
        end
    endtask

    task automatic test_reset_midrun();
        int seen;
        start_job(6'd20, 32'd0, 32'd1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, w_enable, overflow} !== 3'b000 || result !== 32'd0) begin
            bad++;
            $display("FAIL midrun_reset: flags=%b res=%0d want 000/0",
                     {busy, w_enable, overflow}, result);
        end
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            if (w_enable) seen++;
            if (j == 3) rst_n = 1'b1;
        end
        total++;
        if (seen !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrun_nopulse: pulses=%0d busy=%b want 0/0", seen, busy);
        end
        // 2,3 -> 3,5 -> 5,8 -> 8,13: three iterations leave a=8.
        start_job(6'd3, 32'd2, 32'd3, 1'b0, 1'b0);
        wait_job();
        total++;
        if (lat !== 4 || res_cap !== 32'd8 || ovf_cap !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_job: lat=%0d res=%0d ovf=%b want 4/8/0", lat, res_cap, ovf_cap);
        end
    endtask

    // r_enable stays high; inputs change mid-job. Job 1: n=2 from (1,1) -> 2.
    // Job 2 accepted at the first IDLE edge: n=1 from (10,20) -> 20.
    task automatic test_back_to_back();
        start_job(6'd2, 32'd1, 32'd1, 1'b0, 1'b1);
        init_n = 6'd1;
        init_a = 32'd10;
        init_b = 32'd20;
        wait_job();
        total++;
        if (lat !== 3 || res_cap !== 32'd2 || pulse_cnt !== 1 || busy_cnt !== 4) begin
            bad++;
            $display("FAIL b2b_first: lat=%0d res=%0d pulses=%0d busy=%0d want 3/2/1/4",
                     lat, res_cap, pulse_cnt, busy_cnt);
        end
        @(posedge clk);
        #1;
        r_enable = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy got %b want 1", busy);
        end
        wait_job();
        total++;
        if (lat !== 2 || res_cap !== 32'd20) begin
            bad++;
            $display("FAIL b2b_second: lat=%0d res=%0d want 2/20", lat, res_cap);
        end
    endtask

    task automatic test_max_n();
        start_job(6'd63, 32'd0, 32'd0, 1'b0, 1'b0);
        wait_job();
        total++;
        if (lat !== 64 || res_cap !== 32'd0 || ovf_cap !== 1'b0 || busy_cnt !== 65) begin
            bad++;
            $display("FAIL max_n: lat=%0d res=%0d ovf=%b busy=%0d want 64/0/0/65",
                     lat, res_cap, ovf_cap, busy_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_zero_n();
        test_wrap();
        test_saturate();
        test_reset_midrun();
        test_back_to_back();
        test_max_n();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
